// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// Define MULDIV_FAST_MULT_EN for a single-step combinational multiply; divide always iterates.
module mips_cpu_muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int R  = RADIX_BITS;
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2*W-1:0]    prod_r;      // mult: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]      opnd_r;      // multiplicand magnitude or divisor magnitude
  logic              is_div_r;
  logic              dz_r;
  logic              neg_lo_r;
  logic              neg_hi_r;
  logic              busy_r;
  logic              done_r;
  logic              div_zero_r;
  logic [W-1:0]      hi_r;
  logic [W-1:0]      lo_r;

  logic              signed_s;
  logic [W-1:0]      ma_s;
  logic [W-1:0]      mb_s;
  logic [W+R-1:0]    pp_s;
  logic [W+R-1:0]    sum_s;
  logic [2*W-1:0]    mul_next_s;
  logic [W-1:0]      rem_s;
  logic [W-1:0]      quo_s;
  logic [W:0]        trial_s;
  logic [2*W-1:0]    div_next_s;
  logic [2*W-1:0]    fix_prod_s;
  logic [W-1:0]      fix_hi_s;
  logic [W-1:0]      fix_lo_s;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
    if (sgn && v[W-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  // Operand magnitudes, one iteration of each engine, and sign-corrected results.
  always_comb begin
    signed_s = (op == OP_MULT) || (op == OP_DIV);
    ma_s     = magnitude(a, signed_s);
    mb_s     = magnitude(b, signed_s);

    pp_s       = {{R{1'b0}}, opnd_r} * {{W{1'b0}}, prod_r[R-1:0]};
    sum_s      = {{R{1'b0}}, prod_r[2*W-1:W]} + pp_s;
    mul_next_s = {sum_s, prod_r[W-1:R]};

    // Restoring divide, R quotient bits per cycle.
    rem_s   = prod_r[2*W-1:W];
    quo_s   = prod_r[W-1:0];
    trial_s = {(W+1){1'b0}};
    for (int i = 0; i < R; i++) begin
      trial_s = {rem_s, quo_s[W-1]} - {1'b0, opnd_r};
      if (!trial_s[W]) begin
        rem_s = trial_s[W-1:0];
        quo_s = {quo_s[W-2:0], 1'b1};
      end else begin
        rem_s = {rem_s[W-2:0], quo_s[W-1]};
        quo_s = {quo_s[W-2:0], 1'b0};
      end
    end
    div_next_s = {rem_s, quo_s};

    if (neg_lo_r) begin
      fix_prod_s = -prod_r;
      fix_lo_s   = -prod_r[W-1:0];
    end else begin
      fix_prod_s = prod_r;
      fix_lo_s   = prod_r[W-1:0];
    end
    if (neg_hi_r) begin
      fix_hi_s = -prod_r[2*W-1:W];
    end else begin
      fix_hi_s = prod_r[2*W-1:W];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CW{1'b0}};
      prod_r     <= {(2*W){1'b0}};
      opnd_r     <= {W{1'b0}};
      is_div_r   <= 1'b0;
      dz_r       <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_r <= a;
              OP_MTLO: lo_r <= a;
              OP_MULT, OP_MULTU: begin
                is_div_r <= 1'b0;
                dz_r     <= 1'b0;
                neg_lo_r <= signed_s & (a[W-1] ^ b[W-1]);
                neg_hi_r <= signed_s & (a[W-1] ^ b[W-1]);
                opnd_r   <= ma_s;
                cnt_r    <= {CW{1'b0}};
                busy_r   <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                prod_r   <= {{W{1'b0}}, ma_s} * {{W{1'b0}}, mb_s};
                state_r  <= S_FIX;
`else
                prod_r   <= {{W{1'b0}}, mb_s};
                state_r  <= S_RUN;
`endif
              end
              OP_DIV, OP_DIVU: begin
                is_div_r <= 1'b1;
                neg_lo_r <= signed_s & (a[W-1] ^ b[W-1]);
                neg_hi_r <= signed_s & a[W-1];
                prod_r   <= {{W{1'b0}}, ma_s};
                opnd_r   <= mb_s;
                cnt_r    <= {CW{1'b0}};
                busy_r   <= 1'b1;
                if (b == {W{1'b0}}) begin
                  dz_r    <= 1'b1;
                  state_r <= S_FIX;
                end else begin
                  dz_r    <= 1'b0;
                  state_r <= S_RUN;
                end
              end
              default: state_r <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          if (cancel) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            prod_r <= is_div_r ? div_next_s : mul_next_s;
            cnt_r  <= cnt_r + CW'(1);
            if (cnt_r == LAST) begin
              state_r <= S_FIX;
            end
          end
        end
        S_FIX: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          if (!cancel) begin
            done_r     <= 1'b1;
            div_zero_r <= dz_r;
            if (dz_r) begin
              hi_r <= hi_r;
            end else if (is_div_r) begin
              hi_r <= fix_hi_s;
              lo_r <= fix_lo_s;
            end else begin
              {hi_r, lo_r} <= fix_prod_s;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Directed + random scoreboard bench for mips_cpu_muldiv_iter at default parameters.
module tb_mips_cpu_muldiv_iter;

  localparam int W = 32;
  localparam int N = 32;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam int LAT_DIV = N + 1;
`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_MUL = 1;
  localparam logic [2:0] CANCEL_OP = OP_DIV;
`else
  localparam int LAT_MUL = N + 1;
  localparam logic [2:0] CANCEL_OP = OP_MULT;
`endif

  logic clk = 1'b0;
  logic reset, start, cancel;
  logic [2:0] op;
  logic [W-1:0] a, b;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mips_cpu_muldiv_iter #(.WIDTH(W), .RADIX_BITS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current negedge; result ops push their expectation.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sa, sb;
    logic [63:0] ua, ub, r, q, m;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ua = {32'h0, x};
    ub = {32'h0, y};
    e.hi = hi_m; e.lo = lo_m; e.dz = 1'b0; e.lat = LAT_DIV;
    case (o)
      OP_MULT:  begin r = sa * sb; e.hi = r[63:32]; e.lo = r[31:0]; e.lat = LAT_MUL; end
      OP_MULTU: begin r = ua * ub; e.hi = r[63:32]; e.lo = r[31:0]; e.lat = LAT_MUL; end
      OP_DIV, OP_DIVU: begin
        if (y == 32'h0) begin
          e.dz = 1'b1; e.lat = 1;
        end else if (o == OP_DIV) begin
          q = sa / sb; m = sa % sb; e.lo = q[31:0]; e.hi = m[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
      OP_MTHI: hi_m = x;
      OP_MTLO: lo_m = x;
      default: ;
    endcase
    if (o >= OP_MULT && o <= OP_DIVU) begin
      sb_q.push_back(e);
      hi_m = e.hi; lo_m = e.lo;
    end
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    if (!(o >= OP_MULT && o <= OP_DIVU)) begin
      check("mt_hi", hi, hi_m);
      check("mt_lo", lo, lo_m);
      check("mt_busy", busy, 0);
    end
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done();
    int cyc = 0;
    int bcnt = 0;
    exp_t e;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    if (done === 1'b1) begin
      check("sb_nonempty", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("res_hi", hi, e.hi);
        check("res_lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("busy_at_done", busy, 0);
        check("latency", cyc, e.lat);
        check("busy_cycles", bcnt, e.lat);
      end
    end
  endtask

  initial begin
    int seen;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002); wait_done();
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    issue(OP_MTHI, 32'h0000_0011, 32'h0);
    issue(OP_MTLO, 32'h0000_0022, 32'h0);
    issue(OP_DIVU, 32'h0000_1234, 32'h0); wait_done();

    // Cancel mid-run with an ignored MTLO while busy.
    start = 1'b1; op = CANCEL_OP; a = 32'h0000_1234; b = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    check("mtlo_ignored", lo, lo_m);
    repeat (7) @(negedge clk);
    check("busy_before_cancel", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi, hi_m);
    check("cancel_lo", lo, lo_m);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen++; end
    check("cancel_no_done", seen, 0);

    // Reset in the middle of a divide.
    start = 1'b1; op = OP_DIVU; a = 32'h0000_0100; b = 32'h0000_0007;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    hi_m = '0; lo_m = '0;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0004); wait_done();
    check("mult_lo_const", lo, 32'hFFFF_FFF4);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      issue(ro, ra, rb);
      if (ro >= OP_MULT && ro <= OP_DIVU) wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_iter.md
# mips_cpu_muldiv_iter

Iterative, parametrised multiply/divide unit with HI/LO registers for the MIPS-compatible CPU datapath. It replaces the single-cycle HI/LO unit behind the ALU with a `WIDTH`-generic engine that retires `RADIX_BITS` bits per cycle. It exposes a start/busy/done handshake so the control unit can stall on MFHI/MFLO while an operation is in flight. It also supports cancellation and reports divide-by-zero.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; must be even.
- `RADIX_BITS`, 1: quotient/multiplier bits retired per iteration; legal values 1, 2, 4; must divide `WIDTH`.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: request; accepted only when `busy`=0.
- `op` input 3: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000 and 111 are no-ops.
- `cancel` input 1: abort the in-flight operation.
- `a` input WIDTH: multiplicand / dividend / MTHI/MTLO source.
- `b` input WIDTH: multiplier / divisor.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse, HI/LO just updated.
- `div_zero` output 1: one-cycle pulse with `done` when the divisor was 0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- Reset (`reset`=0 at an edge): state IDLE; `hi`=`lo`=0; `busy`=`done`=`div_zero`=0. Reset overrides every other input, including mid-operation.
- IDLE, `start`=1, op MTHI/MTLO: `hi` or `lo` is loaded with `a` at that edge. State stays IDLE; no `busy`, no `done`.
- IDLE, `start`=1, op 000/111: ignored.
- IDLE, `start`=1, MULT/MULTU/DIV/DIVU with `b`≠0 or a multiply: latch operands and op, go to RUN, iteration counter = 0.
  - Signed ops work on magnitudes and record result signs at accept.
- IDLE, `start`=1, DIV/DIVU with `b`=0: go to FIX directly, no iterations. FIX leaves `hi`/`lo` unchanged and pulses `div_zero`.
- RUN: one iteration per cycle, `RADIX_BITS` bits each, for N = `WIDTH`/`RADIX_BITS` cycles, then go to FIX.
  - Multiply: shift-add with a 2·`WIDTH` product.
  - Divide: restoring divide.
- FIX: apply sign correction and write results, then return to IDLE.
  - Multiply: {`hi`,`lo`} = full 2·`WIDTH` product.
  - Divide: `lo` = quotient, `hi` = remainder; the remainder takes the dividend's sign (truncating division).
  - Signed overflow (most-negative / −1): `lo` = most-negative, `hi` = 0.
- `cancel`=1 in RUN or FIX: go to IDLE at that edge. `hi`/`lo` are unchanged; no `done`.
- `start` while `busy`=1 is ignored, including MTHI/MTLO.
- `cancel` in IDLE has no effect. `cancel` and `start` in the same IDLE cycle: `start` wins.

## Timing
- Accept edge k: `busy`=1 from the cycle after k.
- Normal op: RUN occupies edges k+1..k+N and FIX is edge k+N+1. `hi`/`lo` update at edge k+N+1. In the cycle after k+N+1, `done`=1 and `busy`=0.
  - Default parameters (N=32): `done` is seen 33 edges after acceptance.
- Divide-by-zero: FIX at edge k+1; `done`=`div_zero`=1 in the cycle after k+1.
- Back-to-back: a new `start` is accepted in the same cycle that `done` is high.
- `hi`/`lo` are registered outputs. They hold their value throughout RUN: the old value stays readable until the FIX edge.

## Configuration
- `MULDIV_FAST_MULT_EN` defined: MULT/MULTU bypass RUN and compute the product combinationally in one step. State goes IDLE→FIX at accept edge k; `done` is seen after edge k+1. Divide is unchanged.
- Not defined: multiply iterates as described above, N+1 edges.

## Test plan
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> `done` 33 edges after accept; `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 33 cycles.
- DIV `a`=−7, `b`=2 -> `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIV `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU `b`=0 with `hi`=0x11, `lo`=0x22 preloaded via MTHI/MTLO -> `done`+`div_zero` after edge k+1; `hi`=0x11, `lo`=0x22 unchanged.
- MULT started, `cancel` at the 10th RUN cycle -> IDLE next edge, no `done`, `hi`/`lo` unchanged. `start`=MTLO `a`=5 during RUN -> ignored.
- `reset`=0 mid-DIVU -> next cycle `busy`=0, `hi`=`lo`=0. Then issue a fresh MULT −3×4 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4.
- Sweep `RADIX_BITS`=1/2/4 and `MULDIV_FAST_MULT_EN` on/off: 1000 random ops per setting match the reference model. `done` latency = `WIDTH`/`RADIX_BITS`+1 edges (fast multiply: 1).
